pipe_ctrl: RTL

Pipeline sequencing controller for the five-stage integer core. Arbitrates stall requests from fetch, decode and data memory, and branch redirects resolved in EX. Produces one freeze vector for the PC and the four inter-stage registers (if_id, id_ex, ex_mem, mem_wb), plus bubble-injection flushes and the PC redirect. A small FSM holds a redirect that arrives while a fetch is outstanding, until that fetch completes.

---
 rtl/pipe_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the five-stage integer core.
// It arbitrates the fetch, decode and data-memory stall requests and the EX
// branch redirects, and drives the freeze vector, bubble flushes and PC
// redirect. A redirect that arrives while a fetch is outstanding is parked in
// PEND until that fetch returns.
// Optional feature macro: PIPE_CTRL_PERF_EN adds the stall_cycles and
// redirect_cnt performance counters.
// Reset `rst` is asynchronous and active-low.
module pipe_ctrl #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stallreq_if,
   input  logic              stallreq_id,
   input  logic              stallreq_mem,
   input  logic              br_taken_ex,
   input  logic [ADDR_W-1:0] br_target_ex,
   output logic [4:0]        stall,
   output logic              flush_if_id,
   output logic              flush_id_ex,
   output logic              pc_redirect,
   output logic [ADDR_W-1:0] pc_target
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]       stall_cycles,
   output logic [31:0]       redirect_cnt
`endif
);

   localparam int unsigned STALL_W = 5;

   // Freeze patterns: bit 0 pc, 1 if_id, 2 id_ex, 3 ex_mem, 4 mem_wb
   localparam logic [STALL_W-1:0] FRZ_NONE  = STALL_W'(5'b00000);
   localparam logic [STALL_W-1:0] FRZ_PC    = STALL_W'(5'b00001);
   localparam logic [STALL_W-1:0] FRZ_ID    = STALL_W'(5'b00011);
   localparam logic [STALL_W-1:0] FRZ_MEM   = STALL_W'(5'b01111);

   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   tgt_q, tgt_d;
   logic [STALL_W-1:0]  stall_c;
   logic                flush_if_id_c;
   logic                flush_id_ex_c;
   logic                pc_redirect_c;
   logic [ADDR_W-1:0]   pc_target_c;

   // State register and parked redirect target
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
      end
   end

   // Next-state and arbitration: mem stall > branch > load-use > fetch wait
   always_comb begin
      state_d       = state_q;
      tgt_d         = tgt_q;
      stall_c       = FRZ_NONE;
      flush_if_id_c = 1'b0;
      flush_id_ex_c = 1'b0;
      pc_redirect_c = 1'b0;
      pc_target_c   = (state_q == PEND) ? tgt_q : br_target_ex;

      if (stallreq_mem) begin
         // EX is frozen, so any branch there re-asserts once memory releases
         stall_c = FRZ_MEM;
      end else begin
         unique case (state_q)
            RUN: begin
               if (br_taken_ex) begin
                  flush_if_id_c = 1'b1;
                  flush_id_ex_c = 1'b1;
                  if (stallreq_if) begin
                     stall_c = FRZ_PC;
                     tgt_d   = br_target_ex;
                     state_d = PEND;
                  end else begin
                     pc_redirect_c = 1'b1;
                  end
               end else if (stallreq_id) begin
                  stall_c       = FRZ_ID;
                  flush_id_ex_c = 1'b1;
               end else if (stallreq_if) begin
                  stall_c       = FRZ_PC;
                  flush_if_id_c = 1'b1;
               end
            end
            PEND: begin
               flush_if_id_c = 1'b1;
               if (stallreq_if) begin
                  stall_c       = FRZ_PC;
                  flush_id_ex_c = 1'b1;
               end else begin
                  // Fetch returned on the wrong path: discard it and redirect
                  pc_redirect_c = 1'b1;
                  state_d       = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   // Outputs are forced quiet while reset is held
   always_comb begin
      stall       = rst ? stall_c       : FRZ_NONE;
      flush_if_id = rst ? flush_if_id_c : 1'b0;
      flush_id_ex = rst ? flush_id_ex_c : 1'b0;
      pc_redirect = rst ? pc_redirect_c : 1'b0;
      pc_target   = rst ? pc_target_c   : '0;
   end

`ifdef PIPE_CTRL_PERF_EN
   // Saturating counters of stalled edges and issued redirects
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles <= '0;
         redirect_cnt <= '0;
      end else begin
         if ((stall != FRZ_NONE) && (stall_cycles != 32'hFFFF_FFFF))
            stall_cycles <= stall_cycles + 32'd1;
         if (pc_redirect && (redirect_cnt != 32'hFFFF_FFFF))
            redirect_cnt <= redirect_cnt + 32'd1;
      end
   end
`endif

endmodule
